// File: rtl/aha_parallel_to_ahb.sv
// Single-transfer AHB-Lite initiator fed by a parallel register port.
// Each legal request becomes one SINGLE/NONSEQ transfer, answered by ACK/NACK.
module aha_parallel_to_ahb #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter logic [3:0]  HPROT_VAL  = 4'b0011,
    parameter int          WAIT_LIMIT = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [ADDR_WIDTH-1:0] PAR_ADDR,
    input  logic                  PAR_RD_EN,
    input  logic                  PAR_WR_EN,
    input  logic [3:0]            PAR_WR_STRB,
    input  logic [31:0]           PAR_WR_DATA,
    output logic [31:0]           PAR_RD_DATA,
    output logic                  PAR_ACK,
    output logic                  PAR_NACK,
    output logic                  PAR_BUSY,
    output logic                  PAR_DROP,
    output logic                  PAR_TIMEOUT,
    output logic [31:0]           HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic [31:0]           HWDATA,
    input  logic [31:0]           HRDATA,
    input  logic                  HREADY,
    input  logic [1:0]            HRESP
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    localparam int          CW   = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] WMAX = CW'(WAIT_LIMIT);
    localparam logic [1:0]  NONSEQ = 2'b10;

    state_t        state_q, state_d;
    logic [31:0]   haddr_q, haddr_d;
    logic [1:0]    htrans_q, htrans_d;
    logic          hwrite_q, hwrite_d;
    logic [2:0]    hsize_q, hsize_d;
    logic [3:0]    hprot_q, hprot_d;
    logic [31:0]   hwdata_q, hwdata_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ack_q, ack_d;
    logic          nack_q, nack_d;
    logic          busy_q, busy_d;
    logic          drop_q, drop_d;
    logic          tout_q, tout_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic       req, legal, strb_ok;
    logic [2:0] size_w, size_r;
    logic [1:0] off_w, off_r;
    logic       unused_ok;

    assign unused_ok = ^{HRESP[1], PAR_ADDR[1:0]};

    // Map a write strobe to transfer size and byte offset; flag illegal patterns.
    always_comb begin
        size_w  = 3'b010;
        off_w   = 2'd0;
        strb_ok = 1'b1;
        case (PAR_WR_STRB)
            4'b1111: begin size_w = 3'b010; off_w = 2'd0; end
            4'b0011: begin size_w = 3'b001; off_w = 2'd0; end
            4'b1100: begin size_w = 3'b001; off_w = 2'd2; end
            4'b0001: begin size_w = 3'b000; off_w = 2'd0; end
            4'b0010: begin size_w = 3'b000; off_w = 2'd1; end
            4'b0100: begin size_w = 3'b000; off_w = 2'd2; end
            4'b1000: begin size_w = 3'b000; off_w = 2'd3; end
            default: strb_ok = 1'b0;
        endcase
    end

    assign req    = PAR_RD_EN | PAR_WR_EN;
    assign legal  = (PAR_RD_EN ^ PAR_WR_EN) & (PAR_RD_EN | strb_ok);
    assign size_r = PAR_RD_EN ? 3'b010 : size_w;
    assign off_r  = PAR_RD_EN ? 2'd0 : off_w;

    // Next-state and next-output logic; every output is taken from a register.
    always_comb begin
        state_d  = state_q;
        haddr_d  = '0;
        htrans_d = 2'b00;
        hwrite_d = 1'b0;
        hsize_d  = 3'b000;
        hprot_d  = 4'b0000;
        hwdata_d = '0;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        ack_d    = 1'b0;
        nack_d   = 1'b0;
        busy_d   = busy_q;
        drop_d   = 1'b0;
        tout_d   = tout_q;
        cnt_d    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (ack_q | nack_q) begin
                        drop_d = 1'b1;
                    end else if (!legal) begin
                        nack_d = 1'b1;
                    end else begin
                        state_d  = S_ADDR;
                        busy_d   = 1'b1;
                        tout_d   = 1'b0;
                        wr_d     = PAR_WR_EN;
                        wdata_d  = PAR_WR_EN ? PAR_WR_DATA : 32'h0;
                        htrans_d = NONSEQ;
                        haddr_d  = BASE_ADDR |
                                   32'({PAR_ADDR[ADDR_WIDTH-1:2], off_r});
                        hwrite_d = PAR_WR_EN;
                        hsize_d  = size_r;
                        hprot_d  = HPROT_VAL;
                    end
                end
            end
            S_ADDR: begin
                drop_d = req;
                if (HREADY) begin
                    state_d  = S_DATA;
                    hwdata_d = wdata_q;
                end else begin
                    htrans_d = htrans_q;
                    haddr_d  = haddr_q;
                    hwrite_d = hwrite_q;
                    hsize_d  = hsize_q;
                    hprot_d  = hprot_q;
                end
            end
            S_DATA: begin
                drop_d   = req;
                hwdata_d = wdata_q;
                if (HREADY) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    hwdata_d = '0;
                    if (HRESP[0]) begin
                        nack_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                        if (!wr_q) rdata_d = HRDATA;
                    end
                end else if (HRESP[0]) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                drop_d   = req;
                hwdata_d = wdata_q;
                if (HREADY) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    nack_d   = 1'b1;
                    hwdata_d = '0;
                end
            end
        endcase
        if (state_q != S_IDLE && !HREADY) begin
            cnt_d = (cnt_q == WMAX) ? cnt_q : cnt_q + 1'b1;
            if (cnt_d == WMAX) tout_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            haddr_q  <= '0;
            htrans_q <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            hprot_q  <= '0;
            hwdata_q <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            nack_q   <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
            tout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            hprot_q  <= hprot_d;
            hwdata_q <= hwdata_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            nack_q   <= nack_d;
            busy_q   <= busy_d;
            drop_q   <= drop_d;
            tout_q   <= tout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign PAR_RD_DATA = rdata_q;
    assign PAR_ACK     = ack_q;
    assign PAR_NACK    = nack_q;
    assign PAR_BUSY    = busy_q;
    assign PAR_DROP    = drop_q;
    assign PAR_TIMEOUT = tout_q;
    assign HADDR       = haddr_q;
    assign HTRANS      = htrans_q;
    assign HWRITE      = hwrite_q;
    assign HSIZE       = hsize_q;
    assign HBURST      = 3'b000;
    assign HPROT       = hprot_q;
    assign HMASTLOCK   = 1'b0;
    assign HWDATA      = hwdata_q;

endmodule

// File: tb/tb_aha_parallel_to_ahb.sv
// Bench for aha_parallel_to_ahb: directed cases plus randomized transfers
// against a transaction-level timeline model with a randomized AHB slave.
module tb_aha_parallel_to_ahb;

    localparam int          AW   = 12;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          WL   = 6;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [AW-1:0] PAR_ADDR;
    logic          PAR_RD_EN, PAR_WR_EN;
    logic [3:0]    PAR_WR_STRB;
    logic [31:0]   PAR_WR_DATA, PAR_RD_DATA;
    logic          PAR_ACK, PAR_NACK, PAR_BUSY, PAR_DROP, PAR_TIMEOUT;
    logic [31:0]   HADDR, HWDATA, HRDATA;
    logic [1:0]    HTRANS, HRESP;
    logic          HWRITE, HMASTLOCK, HREADY;
    logic [2:0]    HSIZE, HBURST;
    logic [3:0]    HPROT;

    aha_parallel_to_ahb #(
        .ADDR_WIDTH(AW), .BASE_ADDR(BASE),
        .HPROT_VAL(4'b0011), .WAIT_LIMIT(WL)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .PAR_ADDR(PAR_ADDR), .PAR_RD_EN(PAR_RD_EN), .PAR_WR_EN(PAR_WR_EN),
        .PAR_WR_STRB(PAR_WR_STRB), .PAR_WR_DATA(PAR_WR_DATA),
        .PAR_RD_DATA(PAR_RD_DATA), .PAR_ACK(PAR_ACK), .PAR_NACK(PAR_NACK),
        .PAR_BUSY(PAR_BUSY), .PAR_DROP(PAR_DROP), .PAR_TIMEOUT(PAR_TIMEOUT),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] rd_model = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge HCLK);
        #1;
    endtask

    function automatic int popc(input logic [3:0] s);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(s[i]);
        return n;
    endfunction

    function automatic int lowest(input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) return i;
        return 0;
    endfunction

    function automatic bit strb_legal(input logic [3:0] s);
        return popc(s) == 1 || s == 4'b0011 || s == 4'b1100 || s == 4'b1111;
    endfunction

    task automatic idle_inputs;
        PAR_RD_EN = 1'b0;
        PAR_WR_EN = 1'b0;
        HREADY    = 1'b1;
        HRESP     = 2'b00;
        HRDATA    = $urandom;
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_htrans"}, HTRANS, 0);
        check({tag, "_haddr"}, HADDR, 0);
        check({tag, "_hwdata"}, HWDATA, 0);
        check({tag, "_hprot"}, HPROT, 0);
        check({tag, "_hsize"}, HSIZE, 0);
        check({tag, "_hwrite"}, HWRITE, 0);
        check({tag, "_busy"}, PAR_BUSY, 0);
        check({tag, "_ack"}, PAR_ACK, 0);
        check({tag, "_nack"}, PAR_NACK, 0);
        check({tag, "_drop"}, PAR_DROP, 0);
        check({tag, "_tout"}, PAR_TIMEOUT, 0);
        check({tag, "_rdata"}, PAR_RD_DATA, 0);
    endtask

    // One legal request. wa/wd = address/data phase waits, err = ERROR
    // response, drop_at = cycle (1..N) carrying an extra request, 0 = none.
    task automatic xfer(input bit rd, input logic [AW-1:0] addr,
                        input logic [3:0] strb, input logic [31:0] wdat,
                        input int wa, input int wd, input bit err,
                        input logic [31:0] rdat, input int drop_at);
        int          n, sz, d;
        logic [31:0] ea;
        bit          to, ph_a, ph_d;
        sz = rd ? 2 : (popc(strb) == 1 ? 0 : popc(strb) == 2 ? 1 : 2);
        ea = BASE | (32'(addr) & ~32'h3) | (rd ? 0 : 32'(lowest(strb)));
        n  = 3 + wa + wd + int'(err);
        to = (wa >= WL) || (wd + int'(err) >= WL);
        PAR_RD_EN   = rd;
        PAR_WR_EN   = !rd;
        PAR_ADDR    = addr;
        PAR_WR_STRB = strb;
        PAR_WR_DATA = wdat;
        for (int c = 1; c <= n + 1; c++) begin
            step;
            ph_a = (c <= wa + 1);
            ph_d = (c >= wa + 2) && (c < n);
            check("htrans", HTRANS, ph_a ? 2 : 0);
            check("busy", PAR_BUSY, c < n);
            check("ack", PAR_ACK, c == n && !err);
            check("nack", PAR_NACK, c == n && err);
            check("drop", PAR_DROP, drop_at != 0 && c == drop_at + 1);
            check("hburst", HBURST, 0);
            check("hmastlock", HMASTLOCK, 0);
            if (ph_a) begin
                check("haddr", HADDR, ea);
                check("hsize", HSIZE, sz);
                check("hwrite", HWRITE, !rd);
                check("hprot", HPROT, 4'b0011);
            end
            if (ph_d && !rd) check("hwdata", HWDATA, wdat);
            if (c == 1) check("tout_clr", PAR_TIMEOUT, 0);
            if (c == n) begin
                if (rd && !err) rd_model = rdat;
                check("rd_data", PAR_RD_DATA, rd_model);
                check("tout", PAR_TIMEOUT, to);
            end
            idle_inputs();
            PAR_WR_DATA = $urandom;
            PAR_WR_STRB = 4'($urandom);
            if (c <= wa) begin
                HREADY = 1'b0;
            end else if (c > wa + 1 && c < n) begin
                d = c - (wa + 2);
                if (d < wd) begin
                    HREADY = 1'b0;
                end else if (d == wd && err) begin
                    HREADY = 1'b0;
                    HRESP  = 2'b01;
                end else if (d == wd) begin
                    HRDATA = rdat;
                end else begin
                    HRESP = 2'b01;
                end
            end
            if (c == drop_at) begin
                PAR_RD_EN = 1'($urandom_range(0, 1));
                PAR_WR_EN = !PAR_RD_EN;
                PAR_WR_STRB = 4'b1111;
            end
        end
    endtask

    task automatic illegal(input bit rd, input bit wr, input logic [3:0] strb);
        PAR_RD_EN   = rd;
        PAR_WR_EN   = wr;
        PAR_WR_STRB = strb;
        PAR_ADDR    = AW'($urandom);
        step;
        check("ill_nack", PAR_NACK, 1);
        check("ill_busy", PAR_BUSY, 0);
        check("ill_htrans", HTRANS, 0);
        check("ill_ack", PAR_ACK, 0);
        idle_inputs();
        step;
        check("ill_nack2", PAR_NACK, 0);
        check("ill_htrans2", HTRANS, 0);
        check("ill_busy2", PAR_BUSY, 0);
    endtask

    initial begin
        int wa, wd, n, da;
        bit rd, err;
        logic [3:0] s;
        HRESET = 1'b1;
        PAR_ADDR = '0;
        PAR_WR_STRB = '0;
        PAR_WR_DATA = '0;
        idle_inputs();
        step;
        step;
        all_zero("rst");
        check("rst_hburst", HBURST, 0);
        HRESET = 1'b0;

        xfer(1, 12'h010, 4'h0, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, 0);
        xfer(0, 12'h123, 4'b0100, 32'h00AB_0000, 1, 1, 0, 32'h0, 0);
        xfer(1, 12'h200, 4'h0, 32'h0, 0, 0, 1, 32'h1234_5678, 0);
        illegal(0, 1, 4'b0110);
        illegal(1, 1, 4'b1111);
        xfer(0, 12'h044, 4'b1100, 32'hCAFE_0000, 0, 2, 0, 32'h0, 2);
        xfer(1, 12'h0FC, 4'h0, 32'h0, WL, 0, 0, 32'h0BAD_F00D, 0);
        xfer(1, 12'h100, 4'h0, 32'h0, 0, 0, 0, 32'h5555_AAAA, 3);

        PAR_RD_EN = 1'b1;
        PAR_ADDR  = 12'h080;
        step;
        idle_inputs();
        step;
        HRESET = 1'b1;
        HREADY = 1'b0;
        step;
        all_zero("rst_mid");
        rd_model = '0;
        HRESET = 1'b0;
        HREADY = 1'b1;
        step;
        check("rst_mid_ack", PAR_ACK, 0);
        check("rst_mid_busy", PAR_BUSY, 0);
        check("rst_mid_htrans", HTRANS, 0);

        for (int t = 0; t < 80; t++) begin
            rd  = 1'($urandom_range(0, 1));
            s   = 4'($urandom);
            wa  = $urandom_range(0, WL + 1);
            wd  = $urandom_range(0, WL + 1);
            err = ($urandom_range(0, 3) == 0);
            n   = 3 + wa + wd + int'(err);
            da  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
            if ($urandom_range(0, 15) == 0)
                illegal(1, 1, s);
            else if (!rd && !strb_legal(s))
                illegal(0, 1, s);
            else
                xfer(rd, AW'($urandom), s, $urandom, wa, wd, err, $urandom, da);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
